// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator.
// Raster counters are driven by a small RUN/STOP/IDLE controller. A stop request
// never truncates a frame. Every video output is registered and lags the counters
// by one clock.
module video_pattern_gen #(
    parameter int DSIZE    = 8,
    parameter int NUM_D    = 3,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4
) (
    input  logic                   opclk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [1:0]             pattern_sel,
    output logic                   out_vsync,
    output logic                   out_hsync,
    output logic                   out_de,
    output logic [NUM_D*DSIZE-1:0] out_data,
    output logic [15:0]            frame_cnt
);

    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW       = $clog2(H_TOTAL + 1);
    localparam int VW       = $clog2(V_TOTAL + 1);
    localparam int H_BEG_I  = H_SYNC + H_BP;
    localparam int V_BEG_I  = V_SYNC + V_BP;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int SW       = $clog2(BAR_W + 1);
    localparam int PW       = NUM_D * DSIZE;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SY_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_DE_BEG = HW'(H_BEG_I);
    localparam logic [HW-1:0] H_DE_END = HW'(H_BEG_I + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SY_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_DE_BEG = VW'(V_BEG_I);
    localparam logic [VW-1:0] V_DE_END = VW'(V_BEG_I + V_ACTIVE);
    localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);
    localparam logic [DSIZE-1:0] ONES  = {DSIZE{1'b1}};
    localparam logic [DSIZE-1:0] ZERO  = {DSIZE{1'b0}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

    state_t          state_r, state_nxt;
    logic [HW-1:0]   hcnt_r, hcnt_nxt;
    logic [VW-1:0]   vcnt_r, vcnt_nxt;
    logic [1:0]      pat_r;
    logic [2:0]      bar_r, inv_s;
    logic [SW-1:0]   sub_r;
    logic            eof_s, load_s;
    logic            hs_s, vs_s, de_s, chk_s;
    logic [DSIZE-1:0] ramp_s, shift_s;
    logic [PW-1:0]   pix_s;

    assign eof_s  = (state_r != IDLE) && (hcnt_r == H_LAST) && (vcnt_r == V_LAST);
    // Pattern is captured only when a frame is about to start.
    assign load_s = ((state_r == IDLE) && enable) || ((state_r == RUN) && eof_s);

    // Controller state register.
    always_ff @(posedge opclk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt;
    end

    // Controller next state: a stop request only takes effect at end of frame.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (enable) state_nxt = RUN;
                else        state_nxt = IDLE;
            end
            RUN: begin
                if (eof_s)        state_nxt = enable ? RUN : IDLE;
                else if (!enable) state_nxt = STOP;
                else              state_nxt = RUN;
            end
            STOP: begin
                if (eof_s) state_nxt = IDLE;
                else       state_nxt = STOP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster counter next values; counters sit at the origin while idle.
    always_comb begin
        hcnt_nxt = hcnt_r;
        vcnt_nxt = vcnt_r;
        if (state_r == IDLE) begin
            hcnt_nxt = {HW{1'b0}};
            vcnt_nxt = {VW{1'b0}};
        end else if (hcnt_r == H_LAST) begin
            hcnt_nxt = {HW{1'b0}};
            if (vcnt_r == V_LAST) vcnt_nxt = {VW{1'b0}};
            else                  vcnt_nxt = vcnt_r + VW'(1);
        end else begin
            hcnt_nxt = hcnt_r + HW'(1);
        end
    end

    // Raster counters, latched pattern and frame counter.
    always_ff @(posedge opclk or posedge rst) begin
        if (rst) begin
            hcnt_r    <= {HW{1'b0}};
            vcnt_r    <= {VW{1'b0}};
            pat_r     <= 2'd0;
            frame_cnt <= 16'd0;
        end else begin
            hcnt_r <= hcnt_nxt;
            vcnt_r <= vcnt_nxt;
            if (load_s) pat_r <= pattern_sel;
            else        pat_r <= pat_r;
            if (eof_s) frame_cnt <= frame_cnt + 16'd1;
            else       frame_cnt <= frame_cnt;
        end
    end

    // Colour-bar index tracks the current hcnt: cleared just before x=0, then
    // stepped every BAR_W pixels so no divider is needed.
    always_ff @(posedge opclk or posedge rst) begin
        if (rst) begin
            bar_r <= 3'd0;
            sub_r <= {SW{1'b0}};
        end else if ((state_r == IDLE) || (hcnt_nxt == H_DE_BEG)) begin
            bar_r <= 3'd0;
            sub_r <= {SW{1'b0}};
        end else if (sub_r == SUB_LAST) begin
            bar_r <= bar_r + 3'd1;
            sub_r <= {SW{1'b0}};
        end else begin
            bar_r <= bar_r;
            sub_r <= sub_r + SW'(1);
        end
    end

    assign ramp_s  = DSIZE'(32'(hcnt_r) - H_BEG_I);
    assign shift_s = DSIZE'(32'(hcnt_r) - H_BEG_I + 32'(frame_cnt));
    assign chk_s   = 1'((32'(hcnt_r) - H_BEG_I) >> 4) ^ 1'((32'(vcnt_r) - V_BEG_I) >> 4);

    // Sync/enable decode and pixel pattern for the current counter values.
    always_comb begin
        hs_s  = (hcnt_r < H_SY_END);
        vs_s  = (vcnt_r < V_SY_END);
        de_s  = (hcnt_r >= H_DE_BEG) && (hcnt_r < H_DE_END) &&
                (vcnt_r >= V_DE_BEG) && (vcnt_r < V_DE_END);
        inv_s = 3'd7 - bar_r;
        pix_s = {PW{1'b0}};
        case (pat_r)
            2'd0: begin
                for (int k = 0; k < NUM_D; k++) begin
                    pix_s[k*DSIZE +: DSIZE] = inv_s[k % 3] ? ONES : ZERO;
                end
            end
            2'd1:    pix_s = {NUM_D{ramp_s}};
            2'd2:    pix_s = {NUM_D{shift_s}};
            2'd3:    pix_s = {NUM_D{(chk_s ? ONES : ZERO)}};
            default: pix_s = {PW{1'b0}};
        endcase
    end

    // Registered video outputs, blanked while idle and outside the active area.
    always_ff @(posedge opclk or posedge rst) begin
        if (rst) begin
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= {PW{1'b0}};
        end else if (state_r == IDLE) begin
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= {PW{1'b0}};
        end else begin
            out_vsync <= vs_s;
            out_hsync <= hs_s;
            out_de    <= de_s;
            out_data  <= de_s ? pix_s : {PW{1'b0}};
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen using a reduced raster (H 4/4/16/4, V 2/2/4/2).
module tb_video_pattern_gen;

    logic        opclk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        out_vsync, out_hsync, out_de;
    logic [23:0] out_data;
    logic [15:0] frame_cnt;

    int n_run  = 0;
    int n_fail = 0;

    video_pattern_gen #(
        .DSIZE(8), .NUM_D(3),
        .H_SYNC(4), .H_BP(4), .H_ACTIVE(16), .H_FP(4),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(2)
    ) dut (
        .opclk(opclk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de),
        .out_data(out_data), .frame_cnt(frame_cnt)
    );

    always #5 opclk = ~opclk;

    typedef struct {
        int          t;
        logic        en;
        logic [1:0]  sel;
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] data;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int t, input logic vs, input logic hs, input logic de,
                                input logic [23:0] data, input logic [15:0] fc);
        vec_t v;
        v.t = t; v.en = 1'b1; v.sel = 2'd0;
        v.vs = vs; v.hs = hs; v.de = de; v.data = data; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic vs, input logic hs, input logic de,
                           input logic [23:0] data, input logic [15:0] fc);
        chk({name, "_vs"}, 32'(out_vsync), 32'(vs));
        chk({name, "_hs"}, 32'(out_hsync), 32'(hs));
        chk({name, "_de"}, 32'(out_de), 32'(de));
        chk({name, "_data"}, 32'(out_data), 32'(data));
        chk({name, "_fc"}, 32'(frame_cnt), 32'(fc));
    endtask

    task automatic tick();
        @(posedge opclk);
        #1;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic [1:0] sel);
        rst = 1'b1; enable = 1'b0; pattern_sel = sel;
        adv(2);
        rst = 1'b0;
        adv(1);
    endtask

    initial begin
        int cur;
        int de_cnt;

        // Start-up frame with colour bars; t is the edge offset from the enable edge k.
        vecs.push_back(mk(0,   1'b0, 1'b0, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(1,   1'b1, 1'b1, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(4,   1'b1, 1'b1, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(5,   1'b1, 1'b0, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(56,  1'b1, 1'b0, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(57,  1'b0, 1'b1, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(120, 1'b0, 1'b0, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(121, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 16'd0));
        vecs.push_back(mk(122, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 16'd0));
        vecs.push_back(mk(123, 1'b0, 1'b0, 1'b1, 24'hFFFF00, 16'd0));
        vecs.push_back(mk(125, 1'b0, 1'b0, 1'b1, 24'hFF00FF, 16'd0));
        vecs.push_back(mk(127, 1'b0, 1'b0, 1'b1, 24'hFF0000, 16'd0));
        vecs.push_back(mk(129, 1'b0, 1'b0, 1'b1, 24'h00FFFF, 16'd0));
        vecs.push_back(mk(131, 1'b0, 1'b0, 1'b1, 24'h00FF00, 16'd0));
        vecs.push_back(mk(133, 1'b0, 1'b0, 1'b1, 24'h0000FF, 16'd0));
        vecs.push_back(mk(135, 1'b0, 1'b0, 1'b1, 24'h000000, 16'd0));
        vecs.push_back(mk(136, 1'b0, 1'b0, 1'b1, 24'h000000, 16'd0));
        vecs.push_back(mk(137, 1'b0, 1'b0, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(149, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 16'd0));
        vecs.push_back(mk(205, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 16'd0));
        vecs.push_back(mk(232, 1'b0, 1'b0, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(279, 1'b0, 1'b0, 1'b0, 24'h000000, 16'd0));
        vecs.push_back(mk(280, 1'b0, 1'b0, 1'b0, 24'h000000, 16'd1));
        vecs.push_back(mk(281, 1'b1, 1'b1, 1'b0, 24'h000000, 16'd1));

        // Reset state.
        rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
        adv(2);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 24'h0, 16'd0);
        rst = 1'b0;
        adv(3);
        chk_out("idle", 1'b0, 1'b0, 1'b0, 24'h0, 16'd0);

        // Table-driven start-up / colour-bar frame.
        enable = 1'b1;
        tick();
        cur = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            enable      = vecs[i].en;
            pattern_sel = vecs[i].sel;
            adv(vecs[i].t - cur);
            cur = vecs[i].t;
            chk_out($sformatf("bars_t%0d", vecs[i].t), vecs[i].vs, vecs[i].hs,
                    vecs[i].de, vecs[i].data, vecs[i].fc);
        end

        // Graceful stop: enable drops before edge k+150 and returns before edge k+201.
        do_reset(2'd0);
        enable = 1'b1;
        tick();
        de_cnt = 0;
        for (int i = 1; i <= 280; i++) begin
            tick();
            if (out_de) de_cnt++;
            if (i == 149) enable = 1'b0;
            if (i == 200) enable = 1'b1;
        end
        chk("stop_de_count", 32'(de_cnt), 32'd64);
        chk_out("stop_end", 1'b0, 1'b0, 1'b0, 24'h0, 16'd1);
        tick();
        chk_out("stop_idle", 1'b0, 1'b0, 1'b0, 24'h0, 16'd1);
        tick();
        chk_out("stop_restart", 1'b1, 1'b1, 1'b0, 24'h0, 16'd1);

        // Pattern 2: ramp offset by frame count.
        do_reset(2'd2);
        enable = 1'b1;
        tick();
        adv(416);
        chk_out("p2_f2_x15", 1'b0, 1'b0, 1'b1, 24'h101010, 16'd1);
        adv(545);
        chk_out("p2_f4_x0", 1'b0, 1'b0, 1'b1, 24'h030303, 16'd3);
        adv(15);
        chk_out("p2_f4_x15", 1'b0, 1'b0, 1'b1, 24'h121212, 16'd3);

        // Pattern latch: change ramp -> checkerboard mid-frame.
        do_reset(2'd1);
        enable = 1'b1;
        tick();
        adv(150);
        pattern_sel = 2'd3;
        adv(42);
        chk_out("latch_cur", 1'b0, 1'b0, 1'b1, 24'h0F0F0F, 16'd0);
        adv(224);
        chk_out("latch_next", 1'b0, 1'b0, 1'b1, 24'h000000, 16'd1);

        // Asynchronous reset in the middle of the second frame.
        do_reset(2'd0);
        enable = 1'b1;
        tick();
        adv(409);
        chk_out("prerst", 1'b0, 1'b0, 1'b1, 24'h00FFFF, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0, 24'h0, 16'd0);
        adv(2);
        chk_out("rst_held", 1'b0, 1'b0, 1'b0, 24'h0, 16'd0);
        rst = 1'b0;
        tick();
        chk_out("rst_k0", 1'b0, 1'b0, 1'b0, 24'h0, 16'd0);
        tick();
        chk_out("rst_k1", 1'b1, 1'b1, 1'b0, 24'h0, 16'd0);
        adv(120);
        chk_out("rst_k121", 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
